alu_seq_core: RTL and testbench

Multi-cycle ALU execution stage that sits directly upstream of the 32-bit result register `reg_32`. It accepts an operation and two 32-bit operands on a start strobe and computes the result: one cycle for logic, add and shift operations, 32 cycles for shift-and-add multiply. It then presents the result on `res` with a one-cycle `load` pulse. `res` and `load` wire straight to `reg_32`'s `D` and `load`; the same `clear` net resets both blocks.

---
 rtl/alu_seq_core_if.sv | 28 ++
 rtl/alu_seq_core.sv | 172 +++++++++++++++++
 tb/tb_alu_seq_core.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_core_if.sv
// Bus between the issuing stage and alu_seq_core: request side (start/op/A/B)
// and result side (busy/done/load/res/zero/ovf). res/load feed reg_32 directly.
interface alu_seq_core_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             load;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             ovf;

    // Issuing side drives the request and observes the result.
    modport master (
        output start, op, A, B,
        input  busy, done, load, res, zero, ovf
    );

    // ALU side consumes the request and produces the result.
    modport slave (
        input  start, op, A, B,
        output busy, done, load, res, zero, ovf
    );
endinterface

// File: rtl/alu_seq_core.sv
// Multi-cycle ALU execution stage. Single-cycle logic/add/shift ops, 32-cycle
// shift-and-add multiply, result presented with a one-cycle load pulse that
// goes straight into the downstream 32-bit result register.
module alu_seq_core #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          clear,
    alu_seq_core_if.slave bus
);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_NOR = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_MUL,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next_state;

    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;      // operand A; multiplicand during MUL
    logic [WIDTH-1:0] r_b;      // operand B; multiplier during MUL
    logic [WIDTH-1:0] r_acc;
    logic [4:0]       r_cnt;
    logic [WIDTH-1:0] r_res;
    logic             r_zero;
    logic             r_ovf;

    logic             w_busy;
    logic             w_done;
    logic             w_is_sub;
    logic             w_is_addsub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic [WIDTH-1:0] w_alu_res;
    logic             w_alu_ovf;
    logic [WIDTH-1:0] w_acc_next;
    logic             w_mul_last;

    // Shared adder: SUB is A + ~B + 1, so one carry chain serves both.
    assign w_is_sub    = (r_op == OP_SUB);
    assign w_is_addsub = (r_op == OP_ADD) || w_is_sub;
    assign w_b_eff     = w_is_sub ? ~r_b : r_b;
    assign w_sum       = r_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_is_sub};
    assign w_alu_ovf   = w_is_addsub && (r_a[WIDTH-1] == w_b_eff[WIDTH-1])
                                     && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    // One multiply iteration: add the multiplicand when the multiplier LSB is set.
    assign w_acc_next  = r_acc + (r_b[0] ? r_a : '0);
    assign w_mul_last  = (r_cnt == 5'd31);

    // Single-cycle result selection for the EXEC state.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case leaves it unassigned, which would infer a latch.
        w_alu_res = '0;
        case (r_op)
            OP_AND:  w_alu_res = r_a & r_b;
            OP_OR:   w_alu_res = r_a | r_b;
            OP_ADD:  w_alu_res = w_sum;
            OP_SUB:  w_alu_res = w_sum;
            OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(r_a) < $signed(r_b))};
            OP_NOR:  w_alu_res = ~(r_a | r_b);
            OP_SRL:  w_alu_res = r_a >> r_b[4:0];
            default: w_alu_res = '0;   // MUL never passes through EXEC
        endcase
    end

    // State register; clear has priority over any transition.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (clear) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and status outputs decoded from the current state.
    always_comb begin
        w_next_state = r_state;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = (bus.op == OP_MUL) ? S_MUL : S_EXEC;
                end
            end
            S_EXEC: begin
                w_busy       = 1'b1;
                w_next_state = S_DONE;
            end
            S_MUL: begin
                w_busy = 1'b1;
                if (w_mul_last) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Operand capture, multiply iteration and result registers.
    always_ff @(posedge clk) begin
        if (clear) begin
            // NOTE: the operand registers are cleared along with the counter,
            // accumulator and results so nothing downstream ever sees X.
            r_op   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_acc  <= '0;
            r_cnt  <= '0;
            r_res  <= '0;
            r_zero <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_op  <= bus.op;
                        r_a   <= bus.A;
                        r_b   <= bus.B;
                        r_acc <= '0;
                        r_cnt <= '0;
                    end
                end
                S_EXEC: begin
                    r_res  <= w_alu_res;
                    r_zero <= (w_alu_res == '0);
                    r_ovf  <= w_alu_ovf;
                end
                S_MUL: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << 1;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 5'd1;
                    if (w_mul_last) begin
                        r_res  <= w_acc_next;
                        r_zero <= (w_acc_next == '0);
                        r_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = w_busy;
    assign bus.done = w_done;
    assign bus.load = w_done;
    assign bus.res  = r_res;
    assign bus.zero = r_zero;
    assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_alu_seq_core.sv
// Bench for alu_seq_core: directed cases, clear/abort behaviour, back-to-back
// issue and randomized ops compared with an arithmetic reference model. The
// downstream result register is modelled locally to observe what it captures.
module tb_alu_seq_core;

    logic clk;
    logic clear;
    int   total;
    int   bad;
    int   load_count;
    logic [31:0] q;

    alu_seq_core_if #(.WIDTH(32)) bus ();

    alu_seq_core #(.WIDTH(32)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream 32-bit result register and load-pulse counter.
    always @(posedge clk) begin
        if (clear) begin
            q <= '0;
        end else if (bus.load) begin
            q <= bus.res;
            load_count <= load_count + 1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: results from plain arithmetic on the operand values.
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic v);
        longint          sa;
        longint          sb;
        longint          s;
        longint unsigned p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        v  = 1'b0;
        r  = '0;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: begin s = sa + sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd3: begin s = sa - sb; r = s[31:0]; v = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            3'd4: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd5: r = ~(a | b);
            3'd6: r = a >> (b % 32);
            default: begin p = longint'(a) * longint'(b); r = p[31:0]; end
        endcase
    endtask

    // Issue one op, wait (bounded) for done, check timing and result.
    // With disturb set, a start with op=AND is pulsed 10 cycles in; A/B/op
    // are scrambled after acceptance in every case.
    task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input bit disturb);
        logic [31:0] er;
        logic        eo;
        int          lat;
        bit          seen;
        model(op, a, b, er, eo);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = $urandom;
        bus.B     = $urandom;
        bus.op    = 3'($urandom_range(0, 7));
        check({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
        check({name, "_done_early"}, {31'b0, bus.done}, 32'd0);
        seen = 1'b0;
        lat  = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.done) begin
                seen = 1'b1;
                lat  = c;
                break;
            end
            bus.start = disturb && (c == 10);
            if (disturb && (c == 10)) bus.op = 3'd0;
            bus.A = $urandom;
            bus.B = $urandom;
        end
        bus.start = 1'b0;
        check({name, "_done_seen"}, {31'b0, seen}, 32'd1);
        check({name, "_latency"}, lat, (op == 3'd7) ? 32'd32 : 32'd1);
        check({name, "_res"}, bus.res, er);
        check({name, "_zero"}, {31'b0, bus.zero}, {31'b0, (er == 32'd0)});
        check({name, "_ovf"}, {31'b0, bus.ovf}, {31'b0, eo});
        check({name, "_load"}, {31'b0, bus.load}, 32'd1);
        @(posedge clk);
        @(negedge clk);
        check({name, "_done_1cyc"}, {31'b0, bus.done}, 32'd0);
        check({name, "_load_1cyc"}, {31'b0, bus.load}, 32'd0);
        check({name, "_idle"}, {31'b0, bus.busy}, 32'd0);
        check({name, "_q"}, q, er);
    endtask

    initial begin
        int lc0;
        total      = 0;
        bad        = 0;
        load_count = 0;
        clear      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.A      = '0;
        bus.B      = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_res",  bus.res, 32'd0);
        check("rst_zero", {31'b0, bus.zero}, 32'd0);
        check("rst_ovf",  {31'b0, bus.ovf}, 32'd0);
        check("rst_busy", {31'b0, bus.busy}, 32'd0);
        check("rst_done", {31'b0, bus.done}, 32'd0);
        check("rst_load", {31'b0, bus.load}, 32'd0);
        clear = 1'b0;

        // Directed cases
        do_op("add_aa55", 3'd2, 32'hAAAAAAAA, 32'h55555555, 1'b0);
        check("add_aa55_lit", bus.res, 32'hFFFFFFFF);
        check("add_aa55_qlit", q, 32'hFFFFFFFF);
        do_op("sub_55", 3'd3, 32'd5, 32'd5, 1'b0);
        check("sub_55_zlit", {31'b0, bus.zero}, 32'd1);
        do_op("add_ovf", 3'd2, 32'h7FFFFFFF, 32'd1, 1'b0);
        check("add_ovf_lit", {31'b0, bus.ovf}, 32'd1);
        do_op("sub_ovf", 3'd3, 32'h80000000, 32'd1, 1'b0);
        check("sub_ovf_lit", bus.res, 32'h7FFFFFFF);
        do_op("slt_neg", 3'd4, 32'hFFFFFFFF, 32'd1, 1'b0);
        check("slt_neg_lit", bus.res, 32'd1);
        do_op("srl_4", 3'd6, 32'hA5A5A5A5, 32'd4, 1'b0);
        check("srl_4_lit", bus.res, 32'h0A5A5A5A);
        do_op("nor_00", 3'd5, 32'd0, 32'd0, 1'b0);
        do_op("and_x", 3'd0, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0);
        do_op("or_x", 3'd1, 32'h8000_0001, 32'h0000_0100, 1'b0);
        do_op("mul_dist", 3'd7, 32'h0000FFFF, 32'h00010001, 1'b1);
        check("mul_dist_lit", bus.res, 32'hFFFFFFFF);

        // Clear during MUL aborts with no load pulse
        lc0 = load_count;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd7;
        bus.A     = 32'h5A5A5A5A;
        bus.B     = 32'd2;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("clr_busy_before", {31'b0, bus.busy}, 32'd1);
        clear = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear = 1'b0;
        check("clr_res",  bus.res, 32'd0);
        check("clr_zero", {31'b0, bus.zero}, 32'd0);
        check("clr_ovf",  {31'b0, bus.ovf}, 32'd0);
        check("clr_busy", {31'b0, bus.busy}, 32'd0);
        check("clr_done", {31'b0, bus.done}, 32'd0);
        check("clr_load", {31'b0, bus.load}, 32'd0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("clr_no_load", load_count, lc0);
        do_op("add_11", 3'd2, 32'd1, 32'd1, 1'b0);
        check("add_11_lit", bus.res, 32'd2);

        // start together with clear is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.A     = 32'd1;
        bus.B     = 32'd1;
        clear     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        clear     = 1'b0;
        check("sc_busy", {31'b0, bus.busy}, 32'd0);
        check("sc_res",  bus.res, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("sc_busy2", {31'b0, bus.busy}, 32'd0);
        check("sc_done2", {31'b0, bus.done}, 32'd0);

        // start held high: done on every third cycle
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 3'd2;
        bus.A     = 32'd3;
        bus.B     = 32'd4;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b_done_%0d", i), {31'b0, bus.done}, {31'b0, (i % 3) == 1});
            if ((i % 3) == 1) check($sformatf("b2b_res_%0d", i), bus.res, 32'd7);
        end
        bus.start = 1'b0;
        repeat (3) @(posedge clk);

        // Randomized ops against the model
        for (int n = 0; n < 24; n++) begin
            logic [2:0]  rop;
            logic [31:0] ra;
            logic [31:0] rb;
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = $urandom;
            if ((n % 6) == 0) ra = 32'h7FFFFFFF;
            if ((n % 8) == 3) rb = 32'h80000000;
            do_op($sformatf("rnd%0d", n), rop, ra, rb, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
